id_ex_stage: RTL and testbench
==============================

ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 Parameter XLEN, default 64, datapath width of operands and immediate.
REQ-002 Parameter CNT_W, default 32, width of the load-use stall counter.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 ID_Valid  in  1  decode stage holds a real instruction.
REQ-006 ID_ReadData1, ID_ReadData2  in  XLEN  register-file read data.
REQ-007 ID_Imm  in  XLEN  sign-extended immediate.
REQ-008 ID_Rs1, ID_Rs2, ID_Rd  in  5  source and destination register indices.
REQ-009 ID_ALUOp  in  4  ALU operation code (0000 and, 0001 or, 0010 add, 0110 sub, 1100 nor).
REQ-010 ID_ALUSrc, ID_MemRead, ID_MemWrite, ID_RegWrite, ID_MemtoReg, ID_Branch  in  1 each  decoded control.
REQ-011 Flush  in  1  branch redirect; discard instruction in decode.
REQ-012 EXMEM_Rd, MEMWB_Rd  in  5  destination indices of downstream stages.
REQ-013 EXMEM_RegWrite, MEMWB_RegWrite  in  1 each  downstream write enables.
REQ-014 IDEX_Valid, IDEX_ALUSrc, IDEX_MemRead, IDEX_MemWrite, IDEX_RegWrite, IDEX_MemtoReg, IDEX_Branch  out  1 each  registered control.
REQ-015 IDEX_ReadData1, IDEX_ReadData2, IDEX_Imm  out  XLEN  registered operands, feed ALU A, B, IDEX_Imm.
REQ-016 IDEX_Rs1, IDEX_Rs2, IDEX_Rd  out  5  registered indices.
REQ-017 IDEX_ALUOp  out  4  registered ALU opcode.
REQ-018 Forward_A, Forward_B  out  2  ALU operand-source selects.
REQ-019 Stall  out  1  hold PC and IF/ID this cycle.
REQ-020 StallCount  out  CNT_W  number of cycles with Stall=1.

Function
REQ-021 Stall = IDEX_Valid & IDEX_MemRead & (IDEX_Rd != 0) & ID_Valid & ((IDEX_Rd == ID_Rs1) | (IDEX_Rd == ID_Rs2)) & ~Flush, combinational.
REQ-022 Normal edge (Stall=0, Flush=0): all ID_* fields captured into IDEX_* registers; IDEX_Valid <= ID_Valid; latency one cycle.
REQ-023 Edge with Stall=1 or Flush=1: bubble inserted -- every IDEX_* register, including data fields and IDEX_Valid, loads zero.
REQ-024 Flush and load-use hazard in same cycle: Flush wins, Stall=0, bubble inserted, StallCount unchanged.
REQ-025 ID_Valid=0 with Stall=0, Flush=0: fields captured as-is but IDEX_Valid=0; downstream treats as bubble.
REQ-026 Forward_A combinational from IDEX regs: 10 if EXMEM_RegWrite & EXMEM_Rd!=0 & EXMEM_Rd==IDEX_Rs1; else 01 if MEMWB_RegWrite & MEMWB_Rd!=0 & MEMWB_Rd==IDEX_Rs1; else 00.
REQ-027 Forward_B identical rule against IDEX_Rs2, independent of IDEX_ALUSrc (store data needs it).
REQ-028 EX/MEM match takes priority over MEM/WB match when both hit.
REQ-029 Forward_A=Forward_B=00 whenever IDEX_Valid=0.
REQ-030 Encoding 11 never driven.
REQ-031 StallCount increments by 1 on each edge where Stall=1; saturates at all-ones, no wrap.
REQ-032 Only IDEX_* registers and StallCount are state; no other storage.

Reset
REQ-033 reset_n low asynchronously clears every IDEX_* register and StallCount to 0, immediately, without clock.
REQ-034 Consequence during reset: IDEX_Valid=0, Forward_A=Forward_B=00, Stall=0.
REQ-035 Reset asserted mid-stall aborts it; first edge after release captures ID_* normally.

Verification
REQ-036 ID: add x3,x1,x2, RD1=5, RD2=7, ALUOp=0010, Valid=1 -> next edge IDEX_ReadData1=5, ReadData2=7, ALUOp=0010, Rd=3, Valid=1.
REQ-037 IDEX: ld x5 (MemRead=1, Rd=5); ID: sub x6,x5,x1 -> Stall=1, next edge bubble (all IDEX_*=0), StallCount 0->1; following cycle Stall=0, sub captured.
REQ-038 Same load-use plus Flush=1 -> Stall=0, bubble, StallCount unchanged.
REQ-039 IDEX_Rs1=4, IDEX_Rs2=4; EXMEM_Rd=4, RegWrite=1; MEMWB_Rd=4, RegWrite=1 -> Forward_A=Forward_B=10; EXMEM_RegWrite=0 -> 01; both Rd=0 -> 00.
REQ-040 StallCount preloaded via sustained stalls to all-ones, one more stall -> stays all-ones.
REQ-041 reset_n low between edges with IDEX_Valid=1 -> all outputs zero before next clk edge.

Source files
------------

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall detection, flush bubbling,
// operand forwarding selects and a saturating stall-cycle counter.
module id_ex_stage #(
  parameter int XLEN  = 64,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             ID_Valid,
  input  logic [XLEN-1:0]  ID_ReadData1,
  input  logic [XLEN-1:0]  ID_ReadData2,
  input  logic [XLEN-1:0]  ID_Imm,
  input  logic [4:0]       ID_Rs1,
  input  logic [4:0]       ID_Rs2,
  input  logic [4:0]       ID_Rd,
  input  logic [3:0]       ID_ALUOp,
  input  logic             ID_ALUSrc,
  input  logic             ID_MemRead,
  input  logic             ID_MemWrite,
  input  logic             ID_RegWrite,
  input  logic             ID_MemtoReg,
  input  logic             ID_Branch,
  input  logic             Flush,
  input  logic [4:0]       EXMEM_Rd,
  input  logic [4:0]       MEMWB_Rd,
  input  logic             EXMEM_RegWrite,
  input  logic             MEMWB_RegWrite,
  output logic             IDEX_Valid,
  output logic             IDEX_ALUSrc,
  output logic             IDEX_MemRead,
  output logic             IDEX_MemWrite,
  output logic             IDEX_RegWrite,
  output logic             IDEX_MemtoReg,
  output logic             IDEX_Branch,
  output logic [XLEN-1:0]  IDEX_ReadData1,
  output logic [XLEN-1:0]  IDEX_ReadData2,
  output logic [XLEN-1:0]  IDEX_Imm,
  output logic [4:0]       IDEX_Rs1,
  output logic [4:0]       IDEX_Rs2,
  output logic [4:0]       IDEX_Rd,
  output logic [3:0]       IDEX_ALUOp,
  output logic [1:0]       Forward_A,
  output logic [1:0]       Forward_B,
  output logic             Stall,
  output logic [CNT_W-1:0] StallCount
);

  logic hazard_s;
  logic stall_s;
  logic bubble_s;

  // A redirect squashes the dependent instruction, so it must not also stall.
  assign hazard_s = IDEX_Valid & IDEX_MemRead & (IDEX_Rd != 5'd0) & ID_Valid &
                    ((IDEX_Rd == ID_Rs1) | (IDEX_Rd == ID_Rs2));
  assign stall_s  = hazard_s & ~Flush;
  assign bubble_s = stall_s | Flush;
  assign Stall    = stall_s;

  function automatic logic [1:0] fwd_sel(input logic       valid,
                                         input logic [4:0] rs,
                                         input logic       ex_we,
                                         input logic [4:0] ex_rd,
                                         input logic       wb_we,
                                         input logic [4:0] wb_rd);
    logic [1:0] sel;
    sel = 2'b00;
    if (!valid) begin
      sel = 2'b00;
    end else if (ex_we && (ex_rd != 5'd0) && (ex_rd == rs)) begin
      sel = 2'b10;
    end else if (wb_we && (wb_rd != 5'd0) && (wb_rd == rs)) begin
      sel = 2'b01;
    end else begin
      sel = 2'b00;
    end
    return sel;
  endfunction

  // Operand forwarding selects for the instruction currently in EX.
  always_comb begin
    Forward_A = fwd_sel(IDEX_Valid, IDEX_Rs1, EXMEM_RegWrite, EXMEM_Rd,
                        MEMWB_RegWrite, MEMWB_Rd);
    Forward_B = fwd_sel(IDEX_Valid, IDEX_Rs2, EXMEM_RegWrite, EXMEM_Rd,
                        MEMWB_RegWrite, MEMWB_Rd);
  end

  // ID/EX pipeline register: capture decode, or load an all-zero bubble.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n || bubble_s) begin
      IDEX_Valid     <= 1'b0;
      IDEX_ALUSrc    <= 1'b0;
      IDEX_MemRead   <= 1'b0;
      IDEX_MemWrite  <= 1'b0;
      IDEX_RegWrite  <= 1'b0;
      IDEX_MemtoReg  <= 1'b0;
      IDEX_Branch    <= 1'b0;
      IDEX_ReadData1 <= {XLEN{1'b0}};
      IDEX_ReadData2 <= {XLEN{1'b0}};
      IDEX_Imm       <= {XLEN{1'b0}};
      IDEX_Rs1       <= 5'd0;
      IDEX_Rs2       <= 5'd0;
      IDEX_Rd        <= 5'd0;
      IDEX_ALUOp     <= 4'd0;
    end else begin
      IDEX_Valid     <= ID_Valid;
      IDEX_ALUSrc    <= ID_ALUSrc;
      IDEX_MemRead   <= ID_MemRead;
      IDEX_MemWrite  <= ID_MemWrite;
      IDEX_RegWrite  <= ID_RegWrite;
      IDEX_MemtoReg  <= ID_MemtoReg;
      IDEX_Branch    <= ID_Branch;
      IDEX_ReadData1 <= ID_ReadData1;
      IDEX_ReadData2 <= ID_ReadData2;
      IDEX_Imm       <= ID_Imm;
      IDEX_Rs1       <= ID_Rs1;
      IDEX_Rs2       <= ID_Rs2;
      IDEX_Rd        <= ID_Rd;
      IDEX_ALUOp     <= ID_ALUOp;
    end
  end

  // Saturating count of stalled cycles.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      StallCount <= {CNT_W{1'b0}};
    end else if (stall_s && (StallCount != {CNT_W{1'b1}})) begin
      StallCount <= StallCount + CNT_W'(1);
    end else begin
      StallCount <= StallCount;
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Table-driven, scoreboarded bench for id_ex_stage plus hand-written
// forwarding, saturation and reset sequences.
module tb_id_ex_stage;
  localparam int XLEN  = 64;
  localparam int CNT_W = 3;

  localparam logic [5:0] RT = 6'b000100;
  localparam logic [5:0] LD = 6'b110110;
  localparam logic [5:0] ST = 6'b101000;
  localparam logic [5:0] BR = 6'b000001;
  localparam logic [5:0] AI = 6'b100100;

  typedef struct packed {
    logic            valid;
    logic [5:0]      ctrl;
    logic [XLEN-1:0] rd1;
    logic [XLEN-1:0] rd2;
    logic [XLEN-1:0] imm;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [3:0]      aluop;
  } idex_t;

  typedef struct {
    logic            valid;
    logic [4:0]      rs1, rs2, rd;
    logic [3:0]      aluop;
    logic [5:0]      ctrl;
    logic [XLEN-1:0] rd1, rd2, imm;
    logic            flush;
    logic            exp_stall;
  } vec_t;

  logic clk = 1'b0;
  logic reset_n;
  logic ID_Valid, ID_ALUSrc, ID_MemRead, ID_MemWrite, ID_RegWrite, ID_MemtoReg, ID_Branch;
  logic [XLEN-1:0] ID_ReadData1, ID_ReadData2, ID_Imm;
  logic [4:0] ID_Rs1, ID_Rs2, ID_Rd, EXMEM_Rd, MEMWB_Rd;
  logic [3:0] ID_ALUOp;
  logic Flush, EXMEM_RegWrite, MEMWB_RegWrite;
  logic IDEX_Valid, IDEX_ALUSrc, IDEX_MemRead, IDEX_MemWrite, IDEX_RegWrite, IDEX_MemtoReg, IDEX_Branch;
  logic [XLEN-1:0] IDEX_ReadData1, IDEX_ReadData2, IDEX_Imm;
  logic [4:0] IDEX_Rs1, IDEX_Rs2, IDEX_Rd;
  logic [3:0] IDEX_ALUOp;
  logic [1:0] Forward_A, Forward_B;
  logic Stall;
  logic [CNT_W-1:0] StallCount;

  int n_tests = 0;
  int n_fail  = 0;
  idex_t sb_q[$];
  logic [CNT_W-1:0] exp_cnt;
  vec_t tbl[15];

  id_ex_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset_n(reset_n), .ID_Valid(ID_Valid),
    .ID_ReadData1(ID_ReadData1), .ID_ReadData2(ID_ReadData2), .ID_Imm(ID_Imm),
    .ID_Rs1(ID_Rs1), .ID_Rs2(ID_Rs2), .ID_Rd(ID_Rd), .ID_ALUOp(ID_ALUOp),
    .ID_ALUSrc(ID_ALUSrc), .ID_MemRead(ID_MemRead), .ID_MemWrite(ID_MemWrite),
    .ID_RegWrite(ID_RegWrite), .ID_MemtoReg(ID_MemtoReg), .ID_Branch(ID_Branch),
    .Flush(Flush), .EXMEM_Rd(EXMEM_Rd), .MEMWB_Rd(MEMWB_Rd),
    .EXMEM_RegWrite(EXMEM_RegWrite), .MEMWB_RegWrite(MEMWB_RegWrite),
    .IDEX_Valid(IDEX_Valid), .IDEX_ALUSrc(IDEX_ALUSrc), .IDEX_MemRead(IDEX_MemRead),
    .IDEX_MemWrite(IDEX_MemWrite), .IDEX_RegWrite(IDEX_RegWrite),
    .IDEX_MemtoReg(IDEX_MemtoReg), .IDEX_Branch(IDEX_Branch),
    .IDEX_ReadData1(IDEX_ReadData1), .IDEX_ReadData2(IDEX_ReadData2), .IDEX_Imm(IDEX_Imm),
    .IDEX_Rs1(IDEX_Rs1), .IDEX_Rs2(IDEX_Rs2), .IDEX_Rd(IDEX_Rd), .IDEX_ALUOp(IDEX_ALUOp),
    .Forward_A(Forward_A), .Forward_B(Forward_B), .Stall(Stall), .StallCount(StallCount)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish within bound");
    $fatal(1, "timeout");
  end

  function automatic vec_t mk(input logic valid, input logic [4:0] rs1, input logic [4:0] rs2,
                              input logic [4:0] rd, input logic [3:0] op, input logic [5:0] ctrl,
                              input logic [XLEN-1:0] rd1, input logic [XLEN-1:0] rd2,
                              input logic [XLEN-1:0] imm, input logic flush, input logic st);
    vec_t v;
    v.valid = valid; v.rs1 = rs1; v.rs2 = rs2; v.rd = rd; v.aluop = op; v.ctrl = ctrl;
    v.rd1 = rd1; v.rd2 = rd2; v.imm = imm; v.flush = flush; v.exp_stall = st;
    return v;
  endfunction

  function idex_t dut_rec();
    return {IDEX_Valid, IDEX_ALUSrc, IDEX_MemRead, IDEX_MemWrite, IDEX_RegWrite,
            IDEX_MemtoReg, IDEX_Branch, IDEX_ReadData1, IDEX_ReadData2, IDEX_Imm,
            IDEX_Rs1, IDEX_Rs2, IDEX_Rd, IDEX_ALUOp};
  endfunction

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    ID_Valid = v.valid; ID_Rs1 = v.rs1; ID_Rs2 = v.rs2; ID_Rd = v.rd; ID_ALUOp = v.aluop;
    {ID_ALUSrc, ID_MemRead, ID_MemWrite, ID_RegWrite, ID_MemtoReg, ID_Branch} = v.ctrl;
    ID_ReadData1 = v.rd1; ID_ReadData2 = v.rd2; ID_Imm = v.imm; Flush = v.flush;
  endtask

  // One clock: drive, check Stall, predict the register image, clock, compare.
  task automatic apply(input vec_t v, input string name);
    idex_t e;
    drive(v);
    #1;
    check({name, "_stall"}, 256'(Stall), 256'(v.exp_stall));
    if (v.exp_stall || v.flush) e = '0;
    else e = {v.valid, v.ctrl, v.rd1, v.rd2, v.imm, v.rs1, v.rs2, v.rd, v.aluop};
    sb_q.push_back(e);
    if (v.exp_stall && (exp_cnt != 3'b111)) exp_cnt = exp_cnt + 3'd1;
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      check({name, "_sb_empty"}, 256'd1, 256'd0);
    end else begin
      e = sb_q.pop_front();
      check({name, "_idex"}, 256'(dut_rec()), 256'(e));
    end
    check({name, "_cnt"}, 256'(StallCount), 256'(exp_cnt));
  endtask

  initial begin
    reset_n = 1'b0;
    drive(mk(1'b0, 5'd0, 5'd0, 5'd0, 4'd0, 6'd0, 64'd0, 64'd0, 64'd0, 1'b0, 1'b0));
    EXMEM_Rd = 5'd0; MEMWB_Rd = 5'd0; EXMEM_RegWrite = 1'b0; MEMWB_RegWrite = 1'b0;
    exp_cnt = 3'd0;
    #1;
    check("reset_idex", 256'(dut_rec()), 256'd0);
    check("reset_cnt", 256'(StallCount), 256'd0);
    check("reset_fwd", 256'({Forward_A, Forward_B, Stall}), 256'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    tbl[0]  = mk(1'b1, 5'd1, 5'd2, 5'd3, 4'b0010, RT, 64'd5, 64'd7, 64'd0, 1'b0, 1'b0);
    tbl[1]  = mk(1'b1, 5'd2, 5'd0, 5'd5, 4'b0010, LD, 64'd100, 64'd0, 64'd16, 1'b0, 1'b0);
    tbl[2]  = mk(1'b1, 5'd5, 5'd1, 5'd6, 4'b0110, RT, 64'd11, 64'd22, 64'd0, 1'b0, 1'b1);
    tbl[3]  = mk(1'b1, 5'd5, 5'd1, 5'd6, 4'b0110, RT, 64'd11, 64'd22, 64'd0, 1'b0, 1'b0);
    tbl[4]  = mk(1'b1, 5'd3, 5'd0, 5'd7, 4'b0010, LD, 64'd40, 64'd0, 64'd8, 1'b0, 1'b0);
    tbl[5]  = mk(1'b1, 5'd7, 5'd7, 5'd8, 4'b0110, RT, 64'd1, 64'd2, 64'd0, 1'b1, 1'b0);
    tbl[6]  = mk(1'b1, 5'd4, 5'd0, 5'd10, 4'b0010, LD, 64'd3, 64'd0, 64'hFFFF_FFFF_FFFF_FFF8, 1'b0, 1'b0);
    tbl[7]  = mk(1'b0, 5'd10, 5'd3, 5'd11, 4'b0000, RT, 64'd9, 64'd9, 64'd3, 1'b0, 1'b0);
    tbl[8]  = mk(1'b1, 5'd1, 5'd0, 5'd0, 4'b0010, LD, 64'd12, 64'd0, 64'd4, 1'b0, 1'b0);
    tbl[9]  = mk(1'b1, 5'd0, 5'd0, 5'd12, 4'b0001, RT, 64'hA5A5, 64'h5A5A, 64'd0, 1'b0, 1'b0);
    tbl[10] = mk(1'b1, 5'd6, 5'd0, 5'd9, 4'b0010, LD, 64'd60, 64'd0, 64'd24, 1'b0, 1'b0);
    tbl[11] = mk(1'b1, 5'd2, 5'd9, 5'd13, 4'b1100, RT, 64'd77, 64'd88, 64'd0, 1'b0, 1'b1);
    tbl[12] = mk(1'b1, 5'd2, 5'd9, 5'd13, 4'b1100, RT, 64'd77, 64'd88, 64'd0, 1'b0, 1'b0);
    tbl[13] = mk(1'b1, 5'd13, 5'd6, 5'd0, 4'b0110, BR, 64'hDEAD_BEEF_0000_0001, 64'd2, 64'd64, 1'b0, 1'b0);
    tbl[14] = mk(1'b1, 5'd2, 5'd13, 5'd0, 4'b0010, ST, 64'd1000, 64'hCAFE, 64'd32, 1'b0, 1'b0);
    for (int i = 0; i < 15; i++) apply(tbl[i], $sformatf("vec%0d", i));

    // Alternate load / dependent op to push the counter into saturation.
    for (int i = 0; i < 6; i++) begin
      apply(mk(1'b1, 5'd2, 5'd0, 5'd5, 4'b0010, LD, 64'd8, 64'd0, 64'd0, 1'b0, 1'b0), "sat_ld");
      apply(mk(1'b1, 5'd1, 5'd5, 5'd6, 4'b0110, RT, 64'd1, 64'd2, 64'd0, 1'b0, 1'b1), "sat_use");
    end
    check("sat_allones", 256'(StallCount), 256'(3'b111));

    // Forwarding priority, independent of ALUSrc.
    apply(mk(1'b1, 5'd4, 5'd4, 5'd14, 4'b0010, AI, 64'd1, 64'd2, 64'd3, 1'b0, 1'b0), "fwd_setup");
    EXMEM_Rd = 5'd4; EXMEM_RegWrite = 1'b1; MEMWB_Rd = 5'd4; MEMWB_RegWrite = 1'b1;
    #1 check("fwd_both_ex", 256'({Forward_A, Forward_B}), 256'(4'b1010));
    EXMEM_RegWrite = 1'b0;
    #1 check("fwd_both_wb", 256'({Forward_A, Forward_B}), 256'(4'b0101));
    EXMEM_RegWrite = 1'b1; EXMEM_Rd = 5'd9;
    #1 check("fwd_ex_miss", 256'({Forward_A, Forward_B}), 256'(4'b0101));
    EXMEM_Rd = 5'd0; MEMWB_Rd = 5'd0;
    #1 check("fwd_rd0", 256'({Forward_A, Forward_B}), 256'(4'b0000));
    apply(mk(1'b0, 5'd4, 5'd4, 5'd15, 4'b0010, RT, 64'd1, 64'd2, 64'd3, 1'b0, 1'b0), "fwd_inv");
    EXMEM_Rd = 5'd4; MEMWB_Rd = 5'd4;
    #1 check("fwd_invalid", 256'({Forward_A, Forward_B}), 256'(4'b0000));
    EXMEM_Rd = 5'd0; MEMWB_Rd = 5'd0; EXMEM_RegWrite = 1'b0; MEMWB_RegWrite = 1'b0;

    // Asynchronous reset in the middle of a pending load-use stall.
    apply(mk(1'b1, 5'd2, 5'd0, 5'd5, 4'b0010, LD, 64'd8, 64'd0, 64'd0, 1'b0, 1'b0), "rst_ld");
    drive(mk(1'b1, 5'd5, 5'd1, 5'd6, 4'b0110, RT, 64'd1, 64'd2, 64'd0, 1'b0, 1'b0));
    EXMEM_Rd = 5'd2; EXMEM_RegWrite = 1'b1;
    #1 check("rst_pre_stall", 256'({Stall, Forward_A}), 256'(3'b110));
    reset_n = 1'b0;
    #1;
    check("rst_async_idex", 256'(dut_rec()), 256'd0);
    check("rst_async_outs", 256'({Stall, Forward_A, Forward_B, StallCount}), 256'd0);
    exp_cnt = 3'd0;
    #1 reset_n = 1'b1;
    EXMEM_Rd = 5'd0; EXMEM_RegWrite = 1'b0;
    apply(mk(1'b1, 5'd5, 5'd1, 5'd6, 4'b0110, RT, 64'd1, 64'd2, 64'd0, 1'b0, 1'b0), "rst_after");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
